// File: rtl/ifetch_ahb_master_if.sv
// ifetch_ahb_master_if: bundle of AHB-Lite read-side signals plus the core fetch handshake.
//
//   master modport (fetch unit): drives HADDR/HTRANS/HWRITE/HWDATA and the inst_* outputs;
//                                samples HRDATA, fetch_en, redirect_*, inst_ready.
//   slave modport  (ROM + core): the mirror image.
interface ifetch_ahb_master_if;
    logic [63:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;

    modport master (
        output HADDR, HTRANS, HWRITE, HWDATA, inst_valid, inst_data, inst_pc,
        input  HRDATA, fetch_en, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HWDATA, inst_valid, inst_data, inst_pc,
        output HRDATA, fetch_en, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifetch_ahb_master.sv
// ifetch_ahb_master: byte-wide instruction fetch over AHB-Lite. Each instruction is read one
// byte per beat (NONSEQ then SEQ), assembled little-endian and held until the core takes it.
//
// Ports:
//   HCLK   - clock, rising edge
//   HRESET - asynchronous active-low reset
//   bus    - ifetch_ahb_master_if.master (AHB address/data phase + core fetch handshake)
//
// Build option: define IFETCH_RVC_EN to stop after two beats when byte 0 marks a
// compressed (16-bit) instruction; otherwise every instruction is four bytes.
module ifetch_ahb_master #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [1:0]  IDLE_TRANS = 2'b00
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    ifetch_ahb_master_if.master        bus
);

    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StLast, StHold} state_e;

    state_e          state_q, state_d;
    logic [1:0]      beat_q, beat_d;
    logic [63:0]     pc_q, pc_d;
    logic [3:0][7:0] data_q, data_d;
    logic [63:0]     inst_len;

    logic [63:0]     haddr;
    logic [1:0]      htrans;
    logic            inst_valid;

    // Only the low byte lane carries instruction data.
    logic unused_hrdata;
    assign unused_hrdata = ^bus.HRDATA[63:8];

`ifdef IFETCH_RVC_EN
    logic comp_q, comp_d;
    assign inst_len = comp_q ? 64'd2 : 64'd4;
`else
    assign inst_len = 64'd4;
`endif

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        pc_d       = pc_q;
        data_d     = data_q;
`ifdef IFETCH_RVC_EN
        comp_d     = comp_q;
`endif
        haddr      = 64'h0;
        htrans     = IDLE_TRANS;
        inst_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.fetch_en) begin
                    state_d = StReq;
                    beat_d  = 2'd0;
                end
            end
            StReq: begin
                haddr  = pc_q + {62'h0, beat_q};
                htrans = (beat_q == 2'd0) ? TransNonseq : TransSeq;
                if (beat_q == 2'd0) begin
                    // Clear so a short instruction leaves the upper half zero.
                    data_d = '0;
`ifdef IFETCH_RVC_EN
                    comp_d = 1'b0;
`endif
                end else begin
                    // Data phase of the previous beat lands now.
                    data_d[beat_q - 2'd1] = bus.HRDATA[7:0];
                end
                if (beat_q == 2'd3) begin
                    state_d = StLast;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
`ifdef IFETCH_RVC_EN
                // Byte 0 low bits != 2'b11 marks a 16-bit instruction.
                if (beat_q == 2'd1 && bus.HRDATA[1:0] != 2'b11) begin
                    state_d = StLast;
                    beat_d  = beat_q;
                    comp_d  = 1'b1;
                end
`endif
            end
            StLast: begin
                // beat_q still names the last address beat, i.e. the final byte index.
                data_d[beat_q] = bus.HRDATA[7:0];
                state_d        = StHold;
            end
            StHold: begin
                inst_valid = 1'b1;
                if (bus.inst_ready) begin
                    pc_d    = pc_q + inst_len;
                    beat_d  = 2'd0;
                    state_d = bus.fetch_en ? StReq : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides everything, including a completing handshake's pc step.
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            beat_d  = 2'd0;
            data_d  = '0;
            state_d = bus.fetch_en ? StReq : StIdle;
`ifdef IFETCH_RVC_EN
            comp_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q <= StIdle;
            beat_q  <= 2'd0;
            pc_q    <= RESET_PC;
            data_q  <= '0;
`ifdef IFETCH_RVC_EN
            comp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
`ifdef IFETCH_RVC_EN
            comp_q  <= comp_d;
`endif
        end
    end

    assign bus.HADDR      = haddr;
    assign bus.HTRANS     = htrans;
    assign bus.HWRITE     = 1'b0;
    assign bus.HWDATA     = 64'h0;
    assign bus.inst_valid = inst_valid;
    assign bus.inst_data  = inst_valid ? data_q : 32'h0;
    assign bus.inst_pc    = inst_valid ? pc_q : 64'h0;

endmodule

// File: tb/tb_ifetch_ahb_master.sv
// tb_ifetch_ahb_master: directed bench for ifetch_ahb_master. A ROM returns byte[i] = i[7:0]
// one cycle after each address phase. A second instance starts near the top of the address
// space to exercise wrap-around.
module tb_ifetch_ahb_master;

    logic HCLK;
    logic HRESET;
    int   n_checks;
    int   n_errors;

    ifetch_ahb_master_if bus_if ();
    ifetch_ahb_master_if w_if ();

    ifetch_ahb_master #(
        .RESET_PC   (64'h0),
        .IDLE_TRANS (2'b00)
    ) u_dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus_if)
    );

    ifetch_ahb_master #(
        .RESET_PC   (64'hFFFF_FFFF_FFFF_FFFE),
        .IDLE_TRANS (2'b00)
    ) u_wrap (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (w_if)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // ROM data phase: byte at the previous address, valid one cycle later.
    always @(posedge HCLK) begin
        if (bus_if.HTRANS[1]) bus_if.HRDATA <= {56'h0, bus_if.HADDR[7:0]};
        if (w_if.HTRANS[1])   w_if.HRDATA   <= {56'h0, w_if.HADDR[7:0]};
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_valid(input bit wrap, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(wrap ? w_if.inst_valid : bus_if.inst_valid) && n < 20);
    endtask

    task automatic test_reset();
        HRESET = 1'b0;
        bus_if.fetch_en = 1'b0; bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc = 64'h0; bus_if.inst_ready = 1'b0; bus_if.HRDATA = 64'h0;
        w_if.fetch_en = 1'b0; w_if.redirect_valid = 1'b0;
        w_if.redirect_pc = 64'h0; w_if.inst_ready = 1'b0; w_if.HRDATA = 64'h0;
        repeat (3) tick();
        n_checks++;
        if (bus_if.inst_valid !== 1'b0 || bus_if.inst_data !== 32'h0 || bus_if.inst_pc !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_inst: valid=%b data=%h pc=%h required 0/0/0",
                     bus_if.inst_valid, bus_if.inst_data, bus_if.inst_pc);
        end
        n_checks++;
        if (bus_if.HADDR !== 64'h0 || bus_if.HTRANS !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_bus: HADDR=%h HTRANS=%b required 0/00",
                     bus_if.HADDR, bus_if.HTRANS);
        end
        n_checks++;
        if (bus_if.HWRITE !== 1'b0 || bus_if.HWDATA !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_write: HWRITE=%b HWDATA=%h required 0/0",
                     bus_if.HWRITE, bus_if.HWDATA);
        end
        HRESET = 1'b1;
        tick();
        n_checks++;
        if (bus_if.HTRANS !== 2'b00) begin
            n_errors++;
            $display("FAIL idle_no_fetch: HTRANS=%b required 00", bus_if.HTRANS);
        end
    endtask

    task automatic test_basic_fetch();
        logic [1:0] exp_trans [4];
        exp_trans = '{2'b10, 2'b11, 2'b11, 2'b11};
        bus_if.fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (bus_if.HADDR !== 64'(i) || bus_if.HTRANS !== exp_trans[i]) begin
                n_errors++;
                $display("FAIL beat%0d: HADDR=%h HTRANS=%b required %h/%b",
                         i, bus_if.HADDR, bus_if.HTRANS, 64'(i), exp_trans[i]);
            end
        end
        tick();
        n_checks++;
        if (bus_if.HTRANS !== 2'b00 || bus_if.inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL last_phase: HTRANS=%b valid=%b required 00/0",
                     bus_if.HTRANS, bus_if.inst_valid);
        end
        tick();
        n_checks++;
        if (bus_if.inst_valid !== 1'b1 || bus_if.inst_data !== 32'h03020100 ||
            bus_if.inst_pc !== 64'h0) begin
            n_errors++;
            $display("FAIL first_inst: valid=%b data=%h pc=%h required 1/03020100/0",
                     bus_if.inst_valid, bus_if.inst_data, bus_if.inst_pc);
        end
    endtask

    task automatic test_hold();
        int n;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (bus_if.inst_valid !== 1'b1 || bus_if.inst_data !== 32'h03020100 ||
                bus_if.HTRANS !== 2'b00) begin
                n_errors++;
                $display("FAIL hold_cycle%0d: valid=%b data=%h HTRANS=%b required 1/03020100/00",
                         i, bus_if.inst_valid, bus_if.inst_data, bus_if.HTRANS);
            end
        end
        bus_if.inst_ready = 1'b1;
        tick();
        bus_if.inst_ready = 1'b0;
        n_checks++;
        if (bus_if.HADDR !== 64'h4 || bus_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL hold_release: HADDR=%h HTRANS=%b required 4/10",
                     bus_if.HADDR, bus_if.HTRANS);
        end
        wait_valid(1'b0, n);
        n_checks++;
        if (n != 5 || bus_if.inst_data !== 32'h07060504 || bus_if.inst_pc !== 64'h4) begin
            n_errors++;
            $display("FAIL second_inst: cycles=%0d data=%h pc=%h required 5/07060504/4",
                     n, bus_if.inst_data, bus_if.inst_pc);
        end
    endtask

    task automatic test_redirect();
        int n;
        bus_if.inst_ready = 1'b1;
        tick();
        bus_if.inst_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (bus_if.HADDR !== 64'hA || bus_if.HTRANS !== 2'b11) begin
            n_errors++;
            $display("FAIL pre_redirect_beat2: HADDR=%h HTRANS=%b required a/11",
                     bus_if.HADDR, bus_if.HTRANS);
        end
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 64'h8;
        tick();
        bus_if.redirect_valid = 1'b0;
        n_checks++;
        if (bus_if.HADDR !== 64'h8 || bus_if.HTRANS !== 2'b10 || bus_if.inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL redirect_restart: HADDR=%h HTRANS=%b valid=%b required 8/10/0",
                     bus_if.HADDR, bus_if.HTRANS, bus_if.inst_valid);
        end
        wait_valid(1'b0, n);
        n_checks++;
        if (n != 5 || bus_if.inst_data !== 32'h0B0A0908 || bus_if.inst_pc !== 64'h8) begin
            n_errors++;
            $display("FAIL redirect_inst: cycles=%0d data=%h pc=%h required 5/0b0a0908/8",
                     n, bus_if.inst_data, bus_if.inst_pc);
        end
    endtask

    task automatic test_redirect_handshake();
        int n;
        bus_if.inst_ready     = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 64'h20;
        tick();
        bus_if.inst_ready     = 1'b0;
        bus_if.redirect_valid = 1'b0;
        n_checks++;
        if (bus_if.HADDR !== 64'h20 || bus_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL redirect_handshake: HADDR=%h HTRANS=%b required 20/10",
                     bus_if.HADDR, bus_if.HTRANS);
        end
        wait_valid(1'b0, n);
        n_checks++;
        if (n != 5 || bus_if.inst_data !== 32'h23222120 || bus_if.inst_pc !== 64'h20) begin
            n_errors++;
            $display("FAIL redirect_hs_inst: cycles=%0d data=%h pc=%h required 5/23222120/20",
                     n, bus_if.inst_data, bus_if.inst_pc);
        end
    endtask

    task automatic test_fetch_en_drop();
        int n;
        bus_if.inst_ready = 1'b1;
        tick();
        bus_if.inst_ready = 1'b0;
        bus_if.fetch_en   = 1'b0;
        wait_valid(1'b0, n);
        n_checks++;
        if (n != 5 || bus_if.inst_data !== 32'h27262524 || bus_if.inst_pc !== 64'h24) begin
            n_errors++;
            $display("FAIL fetch_en_drop_inst: cycles=%0d data=%h pc=%h required 5/27262524/24",
                     n, bus_if.inst_data, bus_if.inst_pc);
        end
        bus_if.inst_ready = 1'b1;
        tick();
        bus_if.inst_ready = 1'b0;
        tick();
        n_checks++;
        if (bus_if.HTRANS !== 2'b00 || bus_if.inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_drop: HTRANS=%b valid=%b required 00/0",
                     bus_if.HTRANS, bus_if.inst_valid);
        end
        bus_if.fetch_en = 1'b1;
        tick();
        n_checks++;
        if (bus_if.HADDR !== 64'h28 || bus_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL restart_after_idle: HADDR=%h HTRANS=%b required 28/10",
                     bus_if.HADDR, bus_if.HTRANS);
        end
    endtask

    task automatic test_redirect_to_idle();
        bus_if.fetch_en       = 1'b0;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 64'h30;
        tick();
        bus_if.redirect_valid = 1'b0;
        n_checks++;
        if (bus_if.HTRANS !== 2'b00 || bus_if.inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL redirect_idle: HTRANS=%b valid=%b required 00/0",
                     bus_if.HTRANS, bus_if.inst_valid);
        end
        bus_if.fetch_en = 1'b1;
        tick();
        n_checks++;
        if (bus_if.HADDR !== 64'h30 || bus_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL redirect_idle_start: HADDR=%h HTRANS=%b required 30/10",
                     bus_if.HADDR, bus_if.HTRANS);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        tick();
        n_checks++;
        if (bus_if.HADDR !== 64'h31 || bus_if.HTRANS !== 2'b11) begin
            n_errors++;
            $display("FAIL pre_reset_beat1: HADDR=%h HTRANS=%b required 31/11",
                     bus_if.HADDR, bus_if.HTRANS);
        end
        HRESET = 1'b0;
        #1;
        n_checks++;
        if (bus_if.HADDR !== 64'h0 || bus_if.HTRANS !== 2'b00 || bus_if.inst_valid !== 1'b0 ||
            bus_if.inst_data !== 32'h0 || bus_if.inst_pc !== 64'h0) begin
            n_errors++;
            $display("FAIL async_reset: HADDR=%h HTRANS=%b valid=%b data=%h pc=%h required zeros",
                     bus_if.HADDR, bus_if.HTRANS, bus_if.inst_valid, bus_if.inst_data,
                     bus_if.inst_pc);
        end
        tick();
        HRESET = 1'b1;
        tick();
        n_checks++;
        if (bus_if.HADDR !== 64'h0 || bus_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL refetch_start: HADDR=%h HTRANS=%b required 0/10",
                     bus_if.HADDR, bus_if.HTRANS);
        end
        wait_valid(1'b0, n);
        n_checks++;
        if (n != 5 || bus_if.inst_data !== 32'h03020100 || bus_if.inst_pc !== 64'h0) begin
            n_errors++;
            $display("FAIL refetch_inst: cycles=%0d data=%h pc=%h required 5/03020100/0",
                     n, bus_if.inst_data, bus_if.inst_pc);
        end
        bus_if.fetch_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [63:0] exp_addr [4];
        exp_addr = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1};
        w_if.fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (w_if.HADDR !== exp_addr[i]) begin
                n_errors++;
                $display("FAIL wrap_beat%0d: HADDR=%h required %h", i, w_if.HADDR, exp_addr[i]);
            end
        end
        tick();
        tick();
        n_checks++;
        if (w_if.inst_valid !== 1'b1 || w_if.inst_data !== 32'h0100FFFE ||
            w_if.inst_pc !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_errors++;
            $display("FAIL wrap_inst: valid=%b data=%h pc=%h required 1/0100fffe/fffffffffffffffe",
                     w_if.inst_valid, w_if.inst_data, w_if.inst_pc);
        end
        w_if.inst_ready = 1'b1;
        tick();
        w_if.inst_ready = 1'b0;
        w_if.fetch_en   = 1'b0;
        n_checks++;
        if (w_if.HADDR !== 64'h2 || w_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL wrap_next_pc: HADDR=%h HTRANS=%b required 2/10",
                     w_if.HADDR, w_if.HTRANS);
        end
    endtask

`ifdef IFETCH_RVC_EN
    task automatic test_rvc();
        int n;
        bus_if.fetch_en       = 1'b1;
        bus_if.redirect_valid = 1'b1;
        bus_if.redirect_pc    = 64'h1;
        tick();
        bus_if.redirect_valid = 1'b0;
        n_checks++;
        if (bus_if.HADDR !== 64'h1 || bus_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL rvc_beat0: HADDR=%h HTRANS=%b required 1/10",
                     bus_if.HADDR, bus_if.HTRANS);
        end
        tick();
        tick();
        n_checks++;
        if (bus_if.HTRANS !== 2'b00 || bus_if.inst_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rvc_two_beats: HTRANS=%b valid=%b required 00/0",
                     bus_if.HTRANS, bus_if.inst_valid);
        end
        tick();
        n_checks++;
        if (bus_if.inst_valid !== 1'b1 || bus_if.inst_data !== 32'h00000201 ||
            bus_if.inst_pc !== 64'h1) begin
            n_errors++;
            $display("FAIL rvc_inst: valid=%b data=%h pc=%h required 1/00000201/1",
                     bus_if.inst_valid, bus_if.inst_data, bus_if.inst_pc);
        end
        bus_if.inst_ready = 1'b1;
        tick();
        bus_if.inst_ready = 1'b0;
        n_checks++;
        if (bus_if.HADDR !== 64'h3 || bus_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL rvc_pc_plus2: HADDR=%h HTRANS=%b required 3/10",
                     bus_if.HADDR, bus_if.HTRANS);
        end
        wait_valid(1'b0, n);
        n_checks++;
        if (n != 5 || bus_if.inst_data !== 32'h06050403 || bus_if.inst_pc !== 64'h3) begin
            n_errors++;
            $display("FAIL rvc_full_inst: cycles=%0d data=%h pc=%h required 5/06050403/3",
                     n, bus_if.inst_data, bus_if.inst_pc);
        end
        bus_if.inst_ready = 1'b1;
        tick();
        bus_if.inst_ready = 1'b0;
        n_checks++;
        if (bus_if.HADDR !== 64'h7 || bus_if.HTRANS !== 2'b10) begin
            n_errors++;
            $display("FAIL rvc_pc_plus4: HADDR=%h HTRANS=%b required 7/10",
                     bus_if.HADDR, bus_if.HTRANS);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
`ifdef IFETCH_RVC_EN
        test_rvc();
`else
        test_basic_fetch();
        test_hold();
        test_redirect();
        test_redirect_handshake();
        test_fetch_en_drop();
        test_redirect_to_idle();
        test_reset_mid();
        test_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_ahb_master.md
IFETCH_AHB_MASTER -- requirements
Module: ifetch_ahb_master

Interface
REQ-001 Parameter RESET_PC, 64'h0, address of the first fetch after reset.
REQ-002 Parameter IDLE_TRANS, 2'b00, HTRANS code when no transfer is issued; NONSEQ = 2'b10, SEQ = 2'b11.
REQ-003 HCLK  input  1  bus and core clock; all state updates on the rising edge.
REQ-004 HRESET  input  1  reset, asynchronous, active-low.
REQ-005 HADDR  output  64  byte address driven to the instruction ROM slave.
REQ-006 HTRANS  output  2  transfer type: IDLE, NONSEQ or SEQ.
REQ-007 HWRITE  output  1  constant 0; this block only reads.
REQ-008 HWDATA  output  64  constant 0.
REQ-009 HRDATA  input  64  slave read data; only [7:0] is used; valid one cycle after its address phase.
REQ-010 fetch_en  input  1  core permits new fetches.
REQ-011 redirect_valid  input  1  flush and restart fetching at redirect_pc.
REQ-012 redirect_pc  input  64  new fetch address.
REQ-013 inst_valid  output  1  inst_data and inst_pc hold a complete instruction.
REQ-014 inst_ready  input  1  core accepts the instruction this cycle.
REQ-015 inst_data  output  32  assembled instruction, little-endian (byte at pc in [7:0]).
REQ-016 inst_pc  output  64  address of the delivered instruction.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, LAST and HOLD, plus a 2-bit beat counter and a 64-bit pc register.
REQ-018 IDLE: HTRANS = IDLE_TRANS; move to REQ with beat=0 when fetch_en=1.
REQ-019 REQ beat b: HADDR = pc+b; HTRANS = NONSEQ for b=0 and SEQ otherwise.
REQ-020 The byte for beat b-1 SHALL be captured from HRDATA[7:0] at the end of each REQ cycle with b>=1, and the final byte at the end of LAST.
REQ-021 After the last beat, the FSM SHALL enter LAST (HTRANS = IDLE_TRANS), then enter HOLD with inst_valid=1 and inst_pc=pc.
REQ-022 Latency: first NONSEQ in cycle k gives inst_valid=1 in cycle k+5 for a 4-byte instruction.
REQ-023 HOLD: inst_data and inst_pc SHALL be stable while inst_valid=1 and inst_ready=0; HTRANS = IDLE_TRANS (no prefetch).
REQ-024 HOLD with inst_ready=1: pc advances by the instruction length; go to REQ beat 0 if fetch_en=1, otherwise go to IDLE.
REQ-025 pc arithmetic SHALL wrap modulo 2^64; pc+b SHALL also wrap.
REQ-026 redirect_valid=1 in any state SHALL take priority over every other event.
REQ-027 On redirect, at the next edge: inst_valid=0, in-flight bytes discarded, pc=redirect_pc, state=REQ beat 0 (or IDLE if fetch_en=0).
REQ-028 Redirect in the same cycle as an inst_valid&&inst_ready handshake: the handshake completes, and the pc increment is replaced by redirect_pc.
REQ-029 A fetch_en deassertion mid-instruction SHALL NOT abort it; it only blocks the next start.

Reset
REQ-030 While HRESET=0: state=IDLE, beat=0, pc=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, HADDR=0, HTRANS=IDLE_TRANS, HWRITE=0, HWDATA=0.
REQ-031 Reset mid-transfer SHALL discard all captured bytes; after release, fetching restarts at RESET_PC.

Configuration
REQ-032 Macro IFETCH_RVC_EN: when defined, compressed instructions are supported as follows.
- At the end of REQ beat 1, HRDATA[1:0] (byte 0) is inspected.
- If it is not 2'b11, the FSM goes to LAST after 2 beats.
- inst_data = {16'h0, byte1, byte0}; pc advances by 2; latency is k+3.
REQ-033 Without IFETCH_RVC_EN: always 4 beats, pc always advances by 4, and no byte-0 inspection logic is present.

Verification
REQ-034 ROM byte[i]=i, reset release, fetch_en=1 -> HADDR 0,1,2,3 with HTRANS 10,11,11,11; inst_valid in cycle 5; inst_data=32'h03020100, inst_pc=0.
REQ-035 inst_ready held 0 for 10 cycles -> inst_data stable, HTRANS=00 throughout; ready=1 -> next NONSEQ at HADDR=4 in the following cycle, inst_data=32'h07060504.
REQ-036 redirect_valid=1, redirect_pc=8 during REQ beat 2 -> next cycle HADDR=8 NONSEQ, no inst_valid for the old fetch; delivered inst_data=32'h0B0A0908, inst_pc=8.
REQ-037 RESET_PC=64'hFFFF_FFFF_FFFF_FFFE -> beat addresses ...FFFE, ...FFFF, 0, 1; pc after delivery=2.
REQ-038 IFETCH_RVC_EN defined, byte0=8'h01 -> two beats only, inst_data=32'h0000_xx01, next inst_pc=pc+2; byte0=8'h03 -> four beats, pc+4.
REQ-039 HRESET pulsed low during REQ beat 1 -> all outputs return to reset values immediately; refetch from RESET_PC.
